// File: rtl/cpu_pkg.sv
// Shared core package: fetch FSM states, PC-source codes, reset/exception PCs.
// Imported by the fetch stage, its next-PC helper and the bench.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_J   = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h8000_0004;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response port: req/addr out, ready/rvalid/rdata in.
// master = fetch stage, slave = memory.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/inst_fetch_next_pc.sv
// Next-PC selector: jr > j > taken branch > sequential.
// In: pc_plus4, jump index, imm, jr target, pc_src, branch flags. Out: target.
module next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] index_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] jr_target_i,
  input  logic [1:0]  pc_src_i,
  input  logic        branch_i,
  input  logic        branch_taken_i,
  output logic [31:0] target_o
);

  logic [31:0] br_tgt;
  assign br_tgt = pc_plus4_i + (imm_ext_i << 2);

  // pc_src 11 falls into the jr arm through bit 1
  always_comb begin
    target_o = pc_plus4_i;
    priority case (1'b1)
      pc_src_i[1]:
        target_o = jr_target_i;
      pc_src_i == PC_J:
        target_o = {pc_plus4_i[31:28], index_i, 2'b00};
      branch_i && branch_taken_i:
        target_o = br_tgt;
      default:
        target_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, one fetch per commit, holds inst for decode (macro IF_ALIGN_CHECK_EN).
// Ports: clk, reset, pc_src_i/branch*_i/imm_ext_i/jr_target_i/commit_i, imem, inst/pc/valid/misalign outs.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef IF_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_PC = EXC_PC_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         pc_src_i,
  input  logic               branch_i,
  input  logic               branch_taken_i,
  input  logic [31:0]        imm_ext_i,
  input  logic [31:0]        jr_target_i,
  input  logic               commit_i,
  inst_fetch_if.master       imem,
  output logic [31:0]        inst_o,
  output logic [5:0]         opcode_o,
  output logic [5:0]         funct_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               inst_valid_o,
  output logic               misalign_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        mis_q, mis_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc u_next_pc (
    .pc_plus4_i     (pc_plus4),
    .index_i        (inst_q[25:0]),
    .imm_ext_i      (imm_ext_i),
    .jr_target_i    (jr_target_i),
    .pc_src_i       (pc_src_i),
    .branch_i       (branch_i),
    .branch_taken_i (branch_taken_i),
    .target_o       (target)
  );

`ifndef IF_ALIGN_CHECK_EN
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^target[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (imem.ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          state_d = S_HOLD;
          inst_d  = imem.rdata;
        end
      end
      S_HOLD: begin
        if (commit_i) begin
          state_d = S_REQ;
`ifdef IF_ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            pc_d  = EXC_PC;
            mis_d = 1'b1;
          end else begin
            pc_d = target;
          end
`else
          pc_d = {target[31:2], 2'b00};
`endif
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end

  // held low during reset so nothing is issued before release
  assign imem.req     = (state_q == S_REQ) && !reset;
  assign imem.addr    = pc_q;
  assign inst_o       = inst_q;
  assign opcode_o     = inst_q[31:26];
  assign funct_o      = inst_q[5:0];
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4;
  assign inst_valid_o = (state_q == S_HOLD);
  assign misalign_o   = mis_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level model, memory responder, directed vectors.
// Model compared every cycle plus literal checks from hand-computed values.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic        branch = 1'b0;
  logic        taken = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [31:0] jr_target = '0;
  logic        commit = 1'b0;
  logic [31:0] inst, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic        inst_valid, misalign;

  always #5 clk = ~clk;

  inst_fetch_if mif ();

  inst_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src_i       (pc_src),
    .branch_i       (branch),
    .branch_taken_i (taken),
    .imm_ext_i      (imm_ext),
    .jr_target_i    (jr_target),
    .commit_i       (commit),
    .imem           (mif),
    .inst_o         (inst),
    .opcode_o       (opcode),
    .funct_o        (funct),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .inst_valid_o   (inst_valid),
    .misalign_o     (misalign)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory ----------------
  logic [31:0] mem [logic [31:0]];
  int rv_delay = 1;
  int stall_left = 0;
  bit drop_on_reset = 1'b1;

  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin
    bit a_req, a_rdy, a_rst;
    logic [31:0] a_addr, paddr;
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    mif.ready = 1'b1;
    mif.rvalid = 1'b0;
    mif.rdata = '0;
    forever begin
      @(negedge clk);
      a_req = mif.req;
      a_rdy = mif.ready;
      a_rst = reset;
      a_addr = mif.addr;
      @(posedge clk);
      #1;
      if (a_rst && drop_on_reset) pend = 1'b0;
      if (a_req && a_rdy && !a_rst) begin
        pend = 1'b1;
        cnt = rv_delay;
        paddr = a_addr;
      end
      mif.rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          mif.rvalid = 1'b1;
          mif.rdata = rd(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (a_req && !a_rdy && stall_left > 0) stall_left--;
      mif.ready = (stall_left == 0);
    end
  end

  // ---------------- reference model ----------------
  // Fetch is a transaction: idle -> request accepted (pending) ->
  // response (valid instruction) -> commit (new PC, idle again).
  logic [31:0] m_pc = RESET_PC_DEF;
  logic [31:0] m_inst = '0;
  bit m_pend = 1'b0;
  bit m_valid = 1'b0;
  bit m_mis = 1'b0;

  function automatic logic [32:0] model_next(
    logic [31:0] cur, logic [31:0] ins, logic [1:0] src,
    logic br, logic tk, logic [31:0] imm, logic [31:0] jr);
    logic [31:0] p4, t;
    logic m;
    p4 = cur + 32'd4;
    if (src >= 2'd2) t = jr;
    else if (src == 2'd1) t = {p4[31:28], ins[25:0], 2'b00};
    else if (br && tk) t = p4 + imm * 32'd4;
    else t = p4;
    m = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    if (t % 4 != 0) begin
      t = EXC_PC_DEF;
      m = 1'b1;
    end
`else
    t = t - (t % 4);
`endif
    return {m, t};
  endfunction

  initial begin
    logic [32:0] nx;
    bit exp_req;
    forever begin
      @(negedge clk);
      exp_req = !reset && !m_pend && !m_valid;
      chk("req", mif.req, exp_req);
      chk("addr", mif.addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("inst_valid", inst_valid, m_valid);
      chk("misalign", misalign, m_mis);
      chk("inst", inst, m_inst);
      chk("opcode", opcode, m_inst[31:26]);
      chk("funct", funct, m_inst[5:0]);
      if (reset) begin
        m_pc = RESET_PC_DEF;
        m_inst = '0;
        m_pend = 1'b0;
        m_valid = 1'b0;
        m_mis = 1'b0;
      end else begin
        m_mis = 1'b0;
        if (exp_req && mif.ready) begin
          m_pend = 1'b1;
        end else if (m_pend && mif.rvalid) begin
          m_pend = 1'b0;
          m_valid = 1'b1;
          m_inst = mif.rdata;
        end else if (m_valid && commit) begin
          nx = model_next(m_pc, m_inst, pc_src, branch, taken,
                          imm_ext, jr_target);
          m_pc = nx[31:0];
          m_mis = nx[32];
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!inst_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL wait_valid timeout pc=%h", pc);
    end
  endtask

  task automatic do_commit(logic [1:0] src, logic br, logic tk,
                           logic [31:0] imm, logic [31:0] jr);
    wait_valid();
    pc_src = src;
    branch = br;
    taken = tk;
    imm_ext = imm;
    jr_target = jr;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pc_src = 2'b00;
    branch = 1'b0;
    taken = 1'b0;
  endtask

  initial begin
    mem[32'h0040_0000] = 32'h2008_0005;
    mem[32'h0040_0004] = 32'h0109_5020;
    mem[32'h0040_0008] = 32'h8D2A_0004;
    mem[32'h0040_000C] = 32'h014B_6022;
    mem[32'h0040_0010] = 32'h1109_FFFC;
    mem[32'h0040_0100] = 32'h03E0_0008;

    repeat (3) tick();
    chk("rst_req", mif.req, 1'b0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_mis", misalign, 1'b0);

    reset = 1'b0;
    #1;
    chk("c1_req", mif.req, 1'b1);
    chk("c1_addr", mif.addr, 32'h0040_0000);
    tick();
    chk("c2_valid", inst_valid, 1'b0);
    tick();
    chk("c3_valid", inst_valid, 1'b1);
    chk("c3_opcode", opcode, 6'h08);
    chk("c3_inst", inst, 32'h2008_0005);

    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("seq_pc", pc, 32'h0040_0004);
    chk("seq_valid", inst_valid, 1'b0);
    repeat (3) do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("at_br_pc", pc, 32'h0040_0010);
    do_commit(2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
    chk("br_taken", pc, 32'h0040_0004);
    repeat (3) do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    do_commit(2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    chk("br_not_taken", pc, 32'h0040_0014);

    mem[32'h0040_0000] = 32'h0810_0008;
    do_commit(2'b10, 1'b0, 1'b0, 32'h0, 32'h0040_0000);
    chk("jr_back", pc, 32'h0040_0000);
    wait_valid();
    chk("j_opcode", opcode, 6'h02);
    do_commit(2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("j_pc", pc, 32'h0040_0020);
    do_commit(2'b11, 1'b1, 1'b1, 32'h4, 32'h0040_0100);
    chk("jr11_pc", pc, 32'h0040_0100);

    wait_valid();
    stall_left = 4;
    rv_delay = 3;
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      commit = i[0];
      chk("stall_addr", mif.addr, 32'h0040_0104);
      chk("stall_valid", inst_valid, 1'b0);
      tick();
    end
    commit = 1'b0;
    chk("stall_done", inst_valid, 1'b1);
    chk("stall_pc", pc, 32'h0040_0104);
    rv_delay = 1;

    do_commit(2'b10, 1'b0, 1'b0, 32'h0, 32'h0040_0102);
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h8000_0004);
    chk("mis_pulse", misalign, 1'b1);
    tick();
    chk("mis_end", misalign, 1'b0);
`else
    chk("mis_pc", pc, 32'h0040_0100);
    chk("mis_pulse", misalign, 1'b0);
`endif

    do_commit(2'b10, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4, 32'h0);
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    do_commit(2'b10, 1'b0, 1'b0, 32'h0, 32'h0040_0100);
    wait_valid();
    drop_on_reset = 1'b0;
    rv_delay = 3;
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    stall_left = 6;
    tick();
    reset = 1'b0;
    chk("wrst_pc", pc, 32'h0040_0000);
    chk("wrst_valid", inst_valid, 1'b0);
    chk("wrst_inst", inst, 32'h0);
    tick();
    tick();
    chk("late_rv_valid", inst_valid, 1'b0);
    wait_valid();
    chk("refetch_inst", inst, 32'h0810_0008);
    drop_on_reset = 1'b1;
    rv_delay = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the single-cycle MIPS core: holds the program counter, fetches one 32-bit instruction per retired instruction over a request/response instruction-memory port, and presents the held instruction plus its OpCode/Funct fields to the control decoder. It consumes that decoder's PC-source and branch results, together with the ALU branch outcome, to compute the next PC. A variable-latency memory is tolerated by stalling the core with `inst_valid`.

## Interface
- `RESET_PC`, 32'h0040_0000, PC loaded on reset
- `EXC_PC`, 32'h8000_0004, misalignment handler address (used only with `IF_ALIGN_CHECK_EN`)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `pc_src`  in  2  00 sequential/branch, 01 j/jal, 10 jr/jalr; 11 is treated as 10
- `branch`  in  1  current instruction is a branch
- `branch_taken`  in  1  ALU branch condition true
- `imm_ext`  in  32  sign-extended immediate of the current instruction
- `jr_target`  in  32  rs register value
- `commit`  in  1  core retires the held instruction this cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, equals `pc`
- `imem_ready`  in  1  memory accepts request
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  response data
- `inst`  out  32  held instruction
- `opcode`  out  6  `inst[31:26]`
- `funct`  out  6  `inst[5:0]`
- `pc`  out  32  address of `inst`
- `pc_plus4`  out  32  `pc + 4`
- `inst_valid`  out  1  `inst` is valid and may be executed
- `misalign`  out  1  one-cycle pulse on misaligned next PC

## Operation
- FSM states: REQ (drive `imem_req`), WAIT (await `imem_rvalid`), HOLD (`inst_valid`=1, await `commit`).
- REQ → WAIT on `imem_req && imem_ready`. WAIT → HOLD on `imem_rvalid`; `inst` is captured from `imem_rdata`. HOLD → REQ on `commit`, which loads the next PC.
- Next PC priority:
  - `pc_src[1]`: `jr_target`.
  - Else `pc_src==01`: `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  - Else `branch && branch_taken`: `pc_plus4 + (imm_ext<<2)`.
  - Else `pc_plus4`.
- All arithmetic is 32-bit modulo 2^32. `pc_plus4` at 32'hFFFF_FFFC wraps to 0.
- `commit` is ignored outside HOLD.
- `imem_rvalid` is ignored outside WAIT.
- The memory has at most one outstanding request and shares `reset`.
- `imem_addr` and `pc` stay stable from REQ until the next `commit`.

## Timing
- Reset values:
  - state REQ, `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `misalign`=0.
  - `imem_req`=0 while `reset` is high; 1 in the first cycle after release.
- Minimum loop, with `commit` at cycle c:
  - c+1: REQ, `inst_valid`=0.
  - Accept at c+1, `rvalid` at c+2 → `inst_valid`=1 at c+3.
  - Steady state is 3 cycles per instruction.
- `imem_rvalid` in the acceptance cycle itself is a protocol violation and is ignored.
- `reset` asserted in any state wins: the next cycle is REQ with `pc`=`RESET_PC`, and any in-flight response is dropped.
- `opcode`/`funct`/`pc_plus4` are combinational from registered `inst`/`pc`.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - If the selected next PC has `[1:0]!=0` at `commit`, `pc` loads `EXC_PC`.
  - `misalign`=1 for exactly the following cycle.
- `IF_ALIGN_CHECK_EN` undefined:
  - Next PC bits `[1:0]` are forced to 00.
  - `misalign` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - FSM state encodings.
  - `PC_SEQ`/`PC_J`/`PC_JR` 2-bit constants.
  - Default `RESET_PC`/`EXC_PC` values.
- One combinational sub-module, `next_pc`: inputs `pc_plus4`, `inst[25:0]`, `imm_ext`, `jr_target`, `pc_src`, `branch`, `branch_taken`; output 32-bit target.

## Test plan
- Reset, memory with `ready`=1 and `rvalid` one cycle later returning 32'h2008_0005:
  - `imem_addr`=32'h0040_0000.
  - `inst_valid` rises at cycle 3.
  - `opcode`=6'h08.
- `commit` with `pc_src`=00, `branch`=0 → `pc`=32'h0040_0004 next cycle, `inst_valid`=0.
- Branch at `pc`=32'h0040_0010, `imm_ext`=32'hFFFF_FFFC, `branch_taken`=1 → next `pc`=32'h0040_0004. Same with `branch_taken`=0 → 32'h0040_0014.
- Jumps:
  - j with `inst[25:0]`=26'h010_0008 at `pc`=32'h0040_0000 → 32'h0040_0020.
  - jr with `jr_target`=32'h0040_0100 and `pc_src`=11 → 32'h0040_0100.
- `imem_ready` low for 4 cycles and `rvalid` delayed 3 cycles:
  - `imem_addr` stable throughout.
  - `commit` pulses during WAIT are ignored.
  - `reset` asserted in WAIT → REQ with `pc`=`RESET_PC`, and a late `rvalid` is ignored.
- With `IF_ALIGN_CHECK_EN`, jr to 32'h0040_0102 → `pc`=32'h8000_0004 and a 1-cycle `misalign`. Without the macro → `pc`=32'h0040_0100 and `misalign`=0.
